// File: rtl/resize_pipe_if.sv
// resize_pipe_if: valid/ready bus between a beat source/checker (master) and resize_pipe (slave).
// Ports: in_valid/in_ready/in_data/in_signed    - input beat handshake and per-lane signedness
//        out_valid/out_ready/out_data/out_ovf   - head-of-FIFO beat handshake and per-lane overflow
//        ovf_sticky/ovf_clr                     - accumulated overflow flags and their clear
//        count                                  - FIFO occupancy
interface resize_pipe_if #(
    parameter int IN_W     = 9,
    parameter int OUT_W    = 6,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic [CHANNELS-1:0]       in_signed;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;
    logic [CHANNELS-1:0]       out_ovf;
    logic [CHANNELS-1:0]       ovf_sticky;
    logic                      ovf_clr;
    logic [$clog2(DEPTH):0]    count;
    modport master (
        output in_valid, in_data, in_signed, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, out_ovf, ovf_sticky, count
    );
    modport slave (
        input  in_valid, in_data, in_signed, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, out_ovf, ovf_sticky, count
    );
endinterface

// File: rtl/resize_pipe.sv
// resize_pipe: per-lane sign/zero-extend or truncate, buffered in a DEPTH-entry valid/ready FIFO.
// Ports: clk   - rising-edge clock
//        rst_n - synchronous active-low reset
//        bus   - resize_pipe_if.slave (input beat, output beat, overflow flags, occupancy)
// Option: define RESIZE_SAT_EN to saturate overflowing narrowed lanes instead of wrapping.
module resize_pipe #(
    parameter int IN_W     = 9,
    parameter int OUT_W    = 6,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input logic          clk,
    input logic          rst_n,
    resize_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = CHANNELS * OUT_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0]       r_data [DEPTH];
    logic [CHANNELS-1:0] r_ovf  [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic [CHANNELS-1:0] r_sticky;
    logic [DW-1:0]       w_conv;
    logic [CHANNELS-1:0] w_conv_ovf;
    logic                w_push;
    logic                w_pop;

    assign bus.in_ready   = r_count != FULL;
    assign bus.out_valid  = r_count != '0;
    // Stored entries are not reset, so the head is masked while empty.
    assign bus.out_data   = bus.out_valid ? r_data[r_rptr] : '0;
    assign bus.out_ovf    = bus.out_valid ? r_ovf[r_rptr] : '0;
    assign bus.ovf_sticky = r_sticky;
    assign bus.count      = r_count;
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic [IN_W-1:0] w_x;
        assign w_x = bus.in_data[g*IN_W +: IN_W];
        if (OUT_W > IN_W) begin : g_wide
            assign w_conv[g*OUT_W +: OUT_W] = {{(OUT_W-IN_W){bus.in_signed[g] & w_x[IN_W-1]}}, w_x};
            assign w_conv_ovf[g] = 1'b0;
        end else if (OUT_W == IN_W) begin : g_same
            assign w_conv[g*OUT_W +: OUT_W] = w_x;
            assign w_conv_ovf[g] = 1'b0;
        end else begin : g_narrow
            logic [OUT_W-1:0]      w_trunc;
            logic [IN_W-OUT_W-1:0] w_disc;
            logic                  w_ovf;
            assign w_trunc = w_x[OUT_W-1:0];
            assign w_disc  = w_x[IN_W-1:OUT_W];
            // Signed narrowing is lossless only if the dropped bits all copy the new sign bit.
            assign w_ovf = bus.in_signed[g] ? (w_disc != {(IN_W-OUT_W){w_trunc[OUT_W-1]}}) : |w_disc;
            assign w_conv_ovf[g] = w_ovf;
`ifdef RESIZE_SAT_EN
            localparam logic [OUT_W-1:0] MSB = OUT_W'(1) << (OUT_W - 1);
            // Signed saturation follows the sign of the original input, not of the truncated result.
            assign w_conv[g*OUT_W +: OUT_W] = !w_ovf ? w_trunc :
                                              !bus.in_signed[g] ? {OUT_W{1'b1}} :
                                              w_x[IN_W-1] ? MSB : ~MSB;
`else
            assign w_conv[g*OUT_W +: OUT_W] = w_trunc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= w_conv;
            r_ovf[r_wptr]  <= w_conv_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_sticky <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_sticky <= bus.ovf_clr ? '0 : w_pop ? (r_sticky | bus.out_ovf) : r_sticky;
        end
    end
endmodule

// File: tb/tb_resize_pipe.sv
// tb_resize_pipe: directed self-checking bench for resize_pipe (default, widening and 1-bit configs).
module tb_resize_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    resize_pipe_if #(.IN_W(9), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) bus ();
    resize_pipe_if #(.IN_W(3), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) bus3 ();
    resize_pipe_if #(.IN_W(1), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) bus1 ();

    resize_pipe #(.IN_W(9), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    resize_pipe #(.IN_W(3), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    resize_pipe #(.IN_W(1), .OUT_W(6), .CHANNELS(2), .DEPTH(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef RESIZE_SAT_EN
    localparam logic [5:0] EXP_A0 = 6'h3F;
    localparam logic [5:0] EXP_B1 = 6'h1F;
`else
    localparam logic [5:0] EXP_A0 = 6'h05;
    localparam logic [5:0] EXP_B1 = 6'h20;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Beat A: lane0 unsigned 1C5 (overflows), lane1 signed 1F5 = -11 (fits).
    task automatic drive_a;
        bus.in_data   = {9'h1F5, 9'h1C5};
        bus.in_signed = 2'b10;
    endtask

    task automatic drive_k(input int k);
        bus.in_data   = {9'(k), 9'(k)};
        bus.in_signed = 2'b00;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_signed = '0; bus.out_ready = 0; bus.ovf_clr = 0;
        bus3.in_valid = 0; bus3.in_data = '0; bus3.in_signed = '0; bus3.out_ready = 0; bus3.ovf_clr = 0;
        bus1.in_valid = 0; bus1.in_data = '0; bus1.in_signed = '0; bus1.out_ready = 0; bus1.ovf_clr = 0;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_sticky", bus.ovf_sticky, 0);

        // Beat A, plus widening configs pushed in the same cycle
        drive_a();
        bus.in_valid = 1;
        bus3.in_data = {3'b101, 3'b101}; bus3.in_signed = 2'b10; bus3.in_valid = 1;
        bus1.in_data = {1'b1, 1'b1};     bus1.in_signed = 2'b10; bus1.in_valid = 1;
        tick;
        bus.in_valid = 0; bus3.in_valid = 0; bus1.in_valid = 0;
        chk("a_valid", bus.out_valid, 1);
        chk("a_data", bus.out_data, {6'h35, EXP_A0});
        chk("a_ovf", bus.out_ovf, 2'b01);
        chk("w3_data", bus3.out_data, {6'h3D, 6'h05});
        chk("w3_ovf", bus3.out_ovf, 2'b00);
        chk("w1_data", bus1.out_data, {6'h3F, 6'h01});
        chk("w1_ovf", bus1.out_ovf, 2'b00);
        bus.out_ready = 1;
        tick;
        bus.out_ready = 0;
        chk("a_pop_cnt", bus.count, 0);
        chk("a_sticky", bus.ovf_sticky, 2'b01);

        // Beat B: lane0 unsigned 025 (fits), lane1 signed 0A0 = 160 (overflows); clear races the pop
        bus.in_data = {9'h0A0, 9'h025}; bus.in_signed = 2'b10; bus.in_valid = 1;
        tick;
        bus.in_valid = 0;
        chk("b_data", bus.out_data, {EXP_B1, 6'h25});
        chk("b_ovf", bus.out_ovf, 2'b10);
        bus.out_ready = 1; bus.ovf_clr = 1;
        tick;
        bus.out_ready = 0; bus.ovf_clr = 0;
        chk("clr_wins", bus.ovf_sticky, 0);
        chk("b_pop_cnt", bus.count, 0);

        // Fill to full with out_ready low, then hold a 5th beat
        for (int k = 1; k <= 4; k++) begin
            drive_k(k); bus.in_valid = 1;
            tick;
        end
        chk("full_cnt", bus.count, 4);
        chk("full_ready", bus.in_ready, 0);
        drive_k(5);
        tick;
        chk("held_cnt", bus.count, 4);
        chk("held_head", bus.out_data, {6'd1, 6'd1});
        bus.out_ready = 1;
        tick;
        bus.out_ready = 0;
        chk("pop_full_cnt", bus.count, 3);
        chk("pop_full_ready", bus.in_ready, 1);
        tick;
        bus.in_valid = 0;
        chk("fifth_cnt", bus.count, 4);
        bus.out_ready = 1;
        for (int k = 2; k <= 5; k++) begin
            chk("drain_data", bus.out_data, {6'(k), 6'(k)});
            tick;
        end
        chk("drain_cnt", bus.count, 0);

        // Back-to-back streaming across pointer wrap
        for (int k = 10; k < 20; k++) begin
            drive_k(k); bus.in_valid = 1;
            tick;
            chk("tput_data", bus.out_data, {6'(k), 6'(k)});
            chk("tput_cnt", bus.count, 1);
        end
        bus.in_valid = 0;
        tick;
        bus.out_ready = 0;
        chk("tput_empty", bus.count, 0);

        // Set sticky, queue 3 beats, then reset with a push pending
        drive_a(); bus.in_valid = 1;
        tick;
        bus.in_valid = 0; bus.out_ready = 1;
        tick;
        bus.out_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            drive_k(k); bus.in_valid = 1;
            tick;
        end
        chk("pre_rst_cnt", bus.count, 3);
        chk("pre_rst_sticky", bus.ovf_sticky, 2'b01);
        rst_n = 0; bus.out_ready = 1;
        tick;
        rst_n = 1; bus.in_valid = 0; bus.out_ready = 0;
        chk("mid_rst_cnt", bus.count, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sticky", bus.ovf_sticky, 0);
        chk("mid_rst_ready", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
